// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
// Requester 0 is instruction fetch and requester 1 is data/literal load.
package rom_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner select: a lone requester wins, and on contention the one not granted last wins.
// Latency: zero; backpressure: none (pure function of its inputs).
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates fetch/data reads of a zero-latency ROM; ROM_ARB_RR_EN selects round-robin, otherwise fetch has fixed priority.
// Latency: response valid one cycle after acceptance; backpressure: one response held until its owner's rsp_ready, no grants meanwhile.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [ADDR_WIDTH-1:0]              rom_addr,
  input  logic [DATA_WIDTH-1:0]              rom_dout
);

  state_t                state_q, state_d;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQ-1:0]    grant;
  logic                  last_grant;
  logic                  win;
  logic                  accept;

  rom_arb_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign win = grant[REQ_DATA];

`ifdef ROM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= win;
    end
  end

  assign last_grant = last_grant_q;
`else
  // Pretending data was granted last makes the picker always favour fetch.
  assign last_grant = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    rom_addr  = addr_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (req_valid != '0)) begin
          req_ready = grant;
          rom_addr  = req_addr[win];
          accept    = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        // Only the owner's ready can retire the response.
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= win;
        data_q  <= rom_dout;
        addr_q  <= rom_addr;
      end
    end
  end

  assign rsp_data = data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM word k = k*3, expected responses queued at grant time and checked when rsp_valid appears.
module tb_rom_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [1:0]          rsp_ready;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_dout;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_resp;
  logic m_last;

  always #5 clk = ~clk;

  assign rom_dout = DW'(rom_addr) * DW'(3);

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout)
  );

  function automatic logic [1:0] pick_model(logic [1:0] v, logic last);
    if (v != 2'b11) return v;
`ifdef ROM_ARB_RR_EN
    return last ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // Advances the reference model across the coming edge, then waits past it.
  task automatic advance();
    logic [1:0] g;
    if (!m_resp) begin
      g = pick_model(req_valid, m_last);
      if (g != 2'b00) begin
        sb.push_back('{owner: g, data: DW'(req_addr[g[1]]) * DW'(3)});
        m_resp = 1'b1;
        m_last = g[1];
      end
    end else if ((rsp_ready & sb[0].owner) != 2'b00) begin
      void'(sb.pop_front());
      m_resp = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
    n_cmp++; if (rom_addr !== '0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    req_valid = 2'b11; req_addr[0] = 8'd2; req_addr[1] = 8'd4;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready_with_req: got %b want 00", req_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_after_edge: got %b want 00", rsp_valid); end
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_addr[0] = 8'd5; rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
    n_cmp++; if (rom_addr !== 8'd5) begin n_bad++; $display("FAIL single_rom_addr: got %0d want 5", rom_addr); end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd15) begin n_bad++; $display("FAIL single_rsp_data: got %0d want 15", rsp_data); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL single_ready_in_resp: got %b want 00", req_ready); end
    n_cmp++; if (rom_addr !== 8'd5) begin n_bad++; $display("FAIL single_rom_addr_hold: got %0d want 5", rom_addr); end
    advance();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL single_idle_after: got %b want 00", rsp_valid); end
    advance();
  endtask

  task automatic test_rr_stream();
    logic [1:0] er, ev;
    int n1 = 0;
    int n1_exp;
    req_valid = 2'b11; req_addr[0] = 8'd2; req_addr[1] = 8'd4; rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      er = m_resp ? 2'b00 : pick_model(req_valid, m_last);
      ev = 2'b00;
      if (m_resp) ev = sb[0].owner;
      if (req_ready[1]) n1++;
      n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL stream_ready c%0d: got %b want %b", c, req_ready, er); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL stream_rsp_valid c%0d: got %b want %b", c, rsp_valid, ev); end
      if (m_resp) begin
        n_cmp++; if (rsp_data !== sb[0].data) begin n_bad++; $display("FAIL stream_rsp_data c%0d: got %0d want %0d", c, rsp_data, sb[0].data); end
      end
      advance();
    end
`ifdef ROM_ARB_RR_EN
    n1_exp = 3;
`else
    n1_exp = 0;
`endif
    n_cmp++; if (n1 !== n1_exp) begin n_bad++; $display("FAIL stream_data_grants: got %0d want %0d", n1, n1_exp); end
    req_valid = 2'b00;
    advance();
  endtask

  task automatic test_backpressure();
    logic [1:0] er, ev;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 0) ? 2'b01 : (c <= 7) ? 2'b10 : 2'b00;
      req_addr[0] = 8'd7; req_addr[1] = 8'd9;
      rsp_ready = (c < 6) ? 2'b10 : 2'b11;
      @(negedge clk);
      er = m_resp ? 2'b00 : pick_model(req_valid, m_last);
      ev = 2'b00;
      if (m_resp) ev = sb[0].owner;
      n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL bp_ready c%0d: got %b want %b", c, req_ready, er); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL bp_rsp_valid c%0d: got %b want %b", c, rsp_valid, ev); end
      if (m_resp) begin
        n_cmp++; if (rsp_data !== sb[0].data) begin n_bad++; $display("FAIL bp_rsp_data c%0d: got %0d want %0d", c, rsp_data, sb[0].data); end
      end
      if (c >= 1 && c <= 5) begin
        n_cmp++; if (rsp_data !== 32'd21) begin n_bad++; $display("FAIL bp_hold_data c%0d: got %0d want 21", c, rsp_data); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] er, ev;
    req_valid = 2'b01; req_addr[0] = 8'd3; rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rm_ready: got %b want 01", req_ready); end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rm_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd9) begin n_bad++; $display("FAIL rm_rsp_data: got %0d want 9", rsp_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rm_rsp_drop: got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL rm_data_clear: got %0d want 0", rsp_data); end
    sb.delete();
    m_resp = 1'b0;
    m_last = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 2'b01;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 2) ? 2'b01 : 2'b00;
      req_addr[0] = 8'd11;
      @(negedge clk);
      er = m_resp ? 2'b00 : pick_model(req_valid, m_last);
      ev = 2'b00;
      if (m_resp) ev = sb[0].owner;
      n_cmp++; if (req_ready !== er) begin n_bad++; $display("FAIL rm_post_ready c%0d: got %b want %b", c, req_ready, er); end
      n_cmp++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL rm_post_rsp_valid c%0d: got %b want %b", c, rsp_valid, ev); end
      if (m_resp) begin
        n_cmp++; if (rsp_data !== sb[0].data) begin n_bad++; $display("FAIL rm_post_data c%0d: got %0d want %0d", c, rsp_data, sb[0].data); end
      end
      if (c == 3) begin
        n_cmp++; if (rsp_data !== 32'd33) begin n_bad++; $display("FAIL rm_post_word: got %0d want 33", rsp_data); end
      end
      advance();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_addr  = '0;
    rsp_ready = 2'b00;
    m_resp    = 1'b0;
    m_last    = 1'b1;
    test_reset();
    test_single();
    test_rr_stream();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
